// File: rtl/cam_frame_writer.sv
//==============================================================================
// cam_frame_writer : frames a camera pixel stream into {tdata,tuser,tlast}
//                    FIFO words, with overflow / short-frame recovery.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module cam_frame_writer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_enable,
  input  logic                                 i_vsync,
  input  logic                                 i_pix_valid,
  input  logic [15:0]                          i_pix_data,
  input  logic                                 i_sready,
  output logic                                 o_wr_valid,
  output logic [TDATA_WIDTH+TUSER_WIDTH:0]     o_wr_data,
  output logic                                 o_frame_active,
  output logic [15:0]                          o_frame_count,
  output logic [15:0]                          o_drop_count,
  output logic                                 o_ovf,
  input  logic                                 i_clr
);

  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int WW = TDATA_WIDTH + TUSER_WIDTH + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2,
    S_DROP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                vsync_q;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                wr_valid_q, wr_valid_d;
  logic [WW-1:0]       wr_data_q, wr_data_d;
  logic                frame_active_q;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                ovf_q, ovf_d;

  logic                sof;
  logic                lost;
  logic                emit;
  logic                drop_evt;
  logic                frame_done;
  logic [CW-1:0]       col_base;
  logic [RW-1:0]       row_base;
  logic                last_col;
  logic                frame_end;
  logic [TUSER_WIDTH-1:0] tuser;

  assign sof = i_vsync & ~vsync_q;
  // The beat that trails a loss is already part of the dropped frame, so a
  // stall seen while in DROP is not counted again.
  assign lost = wr_valid_q & ~i_sready & (state_q != S_DROP);

  always_comb begin
    col_base   = sof ? '0 : col_q;
    row_base   = sof ? '0 : row_q;
    last_col   = (col_base == COL_LAST);
    frame_end  = last_col && (row_base == ROW_LAST);
    state_d    = state_q;
    emit       = 1'b0;
    drop_evt   = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (lost) begin
          drop_evt = 1'b1;
        end else if (sof && i_enable) begin
          state_d = S_ACTIVE;
          emit    = i_pix_valid;
        end else if (!i_enable) begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (sof) begin
          drop_evt = 1'b1;
          if (i_enable) emit = i_pix_valid;
          else          state_d = S_WAIT_SOF;
        end else begin
          emit = i_pix_valid;
          if (lost) begin
            drop_evt = 1'b1;
            state_d  = S_DROP;
          end
        end
        if (emit && frame_end && !drop_evt) begin
          frame_done = 1'b1;
          state_d    = S_WAIT_SOF;
        end
      end
      S_DROP: begin
        if (sof) begin
          if (i_enable) begin
            state_d = S_ACTIVE;
            emit    = i_pix_valid;
          end else begin
            state_d = S_WAIT_SOF;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    col_d = col_base;
    row_d = row_base;
    if (emit) begin
      if (last_col) begin
        col_d = '0;
        row_d = (row_base == ROW_LAST) ? '0 : row_base + RW'(1);
      end else begin
        col_d = col_base + CW'(1);
      end
    end

    tuser    = '0;
    tuser[0] = (col_base == '0) && (row_base == '0);
    wr_valid_d = emit;
    wr_data_d  = emit ? {TDATA_WIDTH'(i_pix_data), tuser, last_col} : '0;

    frame_count_d = frame_count_q + (frame_done ? 16'd1 : 16'd0);

    // A drop in the same cycle as a clear restarts the tally at one.
    drop_count_d = drop_count_q;
    ovf_d        = ovf_q;
    if (drop_evt) begin
      ovf_d        = 1'b1;
      drop_count_d = i_clr ? 16'd1 :
                     ((drop_count_q == 16'hFFFF) ? 16'hFFFF : drop_count_q + 16'd1);
    end else if (i_clr) begin
      ovf_d        = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      vsync_q        <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      wr_valid_q     <= 1'b0;
      wr_data_q      <= '0;
      frame_active_q <= 1'b0;
      frame_count_q  <= '0;
      drop_count_q   <= '0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= i_vsync;
      col_q          <= col_d;
      row_q          <= row_d;
      wr_valid_q     <= wr_valid_d;
      wr_data_q      <= wr_data_d;
      frame_active_q <= (state_d == S_ACTIVE);
      frame_count_q  <= frame_count_d;
      drop_count_q   <= drop_count_d;
      ovf_q          <= ovf_d;
    end
  end

  assign o_wr_valid     = wr_valid_q;
  assign o_wr_data      = wr_data_q;
  assign o_frame_active = frame_active_q;
  assign o_frame_count  = frame_count_q;
  assign o_drop_count   = drop_count_q;
  assign o_ovf          = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_frame_writer.sv
//==============================================================================
// tb_cam_frame_writer : scoreboard bench for cam_frame_writer (4x2 frames).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cam_frame_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int TD = 32;
  localparam int TU = 1;
  localparam int WW = TD + TU + 1;

  logic          clk = 1'b0;
  logic          rst, en, vsync, pvalid, sready, clr;
  logic [15:0]   pdata;
  logic          wr_valid;
  logic [WW-1:0] wr_data;
  logic          frame_active;
  logic [15:0]   frame_count, drop_count;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [WW-1:0] exp_q[$];

  cam_frame_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .TDATA_WIDTH(TD), .TUSER_WIDTH(TU)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_vsync(vsync),
    .i_pix_valid(pvalid), .i_pix_data(pdata), .i_sready(sready),
    .o_wr_valid(wr_valid), .o_wr_data(wr_data), .o_frame_active(frame_active),
    .o_frame_count(frame_count), .o_drop_count(drop_count), .o_ovf(ovf),
    .i_clr(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] beat(input logic [15:0] d, input bit u, input bit l);
    logic [WW-1:0] w;
    w = '0;
    w[WW-1:TU+1] = TD'(d);
    w[1] = u;
    w[0] = l;
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'(wr_valid), 64'd0);
      else                   check("beat", 64'(wr_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [15:0] d, input bit push, input bit u, input bit l);
    pvalid = 1'b1;
    pdata  = d;
    if (push) exp_q.push_back(beat(d, u, l));
    cyc();
    pvalid = 1'b0;
  endtask

  task automatic sof_only();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
  endtask

  task automatic full_frame(input logic [15:0] base, input bit push);
    for (int p = 0; p < H * V; p++)
      pix(base + 16'(p), push, p == 0, (p % H) == H - 1);
  endtask

  task automatic drain(input string tag);
    repeat (3) cyc();
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vsync = 1'b0; pvalid = 1'b0; pdata = '0;
    sready = 1'b1; clr = 1'b0;
    cyc(); cyc();
    check("rst_wr_valid", 64'(wr_valid), 0);
    check("rst_wr_data", 64'(wr_data), 0);
    check("rst_frame_active", 64'(frame_active), 0);
    check("rst_frame_count", 64'(frame_count), 0);
    check("rst_drop_count", 64'(drop_count), 0);
    check("rst_ovf", 64'(ovf), 0);
    rst = 1'b0;

    // Normal frame; a pixel before sof is ignored
    en = 1'b1;
    cyc();
    pix(16'h00AA, 1'b0, 1'b0, 1'b0);
    sof_only();
    check("n_active", 64'(frame_active), 1);
    full_frame(16'h0001, 1'b1);
    cyc();
    check("n_frame_count", 64'(frame_count), 1);
    check("n_drop_count", 64'(drop_count), 0);
    check("n_ovf", 64'(ovf), 0);
    check("n_idle_active", 64'(frame_active), 0);
    drain("n_drained");

    // Backpressure on beat 4
    do_reset();
    sof_only();
    for (int p = 0; p < 5; p++) pix(16'h0011 + 16'(p), 1'b1, p == 0, p == 3);
    sready = 1'b0;
    pix(16'h0016, 1'b1, 1'b0, 1'b0);
    sready = 1'b1;
    pix(16'h0017, 1'b0, 1'b0, 1'b0);
    pix(16'h0018, 1'b0, 1'b0, 1'b0);
    cyc();
    check("bp_ovf", 64'(ovf), 1);
    check("bp_drop_count", 64'(drop_count), 1);
    check("bp_frame_count0", 64'(frame_count), 0);
    check("bp_drop_active", 64'(frame_active), 0);
    sof_only();
    full_frame(16'h0100, 1'b1);
    cyc();
    check("bp_frame_count1", 64'(frame_count), 1);
    check("bp_drop_count_hold", 64'(drop_count), 1);
    drain("bp_drained");

    // Short frame
    do_reset();
    sof_only();
    for (int p = 0; p < 5; p++) pix(16'h0021 + 16'(p), 1'b1, p == 0, p == 3);
    vsync = 1'b1;
    pix(16'h0030, 1'b1, 1'b1, 1'b0);
    vsync = 1'b0;
    for (int p = 1; p < H * V; p++) pix(16'h0030 + 16'(p), 1'b1, 1'b0, (p % H) == H - 1);
    cyc();
    check("sf_drop_count", 64'(drop_count), 1);
    check("sf_ovf", 64'(ovf), 1);
    check("sf_frame_count", 64'(frame_count), 1);
    drain("sf_drained");

    // Disable mid-frame
    do_reset();
    sof_only();
    for (int p = 0; p < 3; p++) pix(16'h0041 + 16'(p), 1'b1, p == 0, 1'b0);
    en = 1'b0;
    for (int p = 3; p < H * V; p++) pix(16'h0041 + 16'(p), 1'b1, 1'b0, (p % H) == H - 1);
    cyc();
    check("dis_frame_count", 64'(frame_count), 1);
    sof_only();
    full_frame(16'h0050, 1'b0);
    cyc();
    check("dis_active", 64'(frame_active), 0);
    check("dis_frame_count_hold", 64'(frame_count), 1);
    drain("dis_drained");

    // Reset mid-frame
    en = 1'b1;
    do_reset();
    sof_only();
    for (int p = 0; p < 3; p++) pix(16'h0061 + 16'(p), 1'b1, p == 0, 1'b0);
    check("mr_pre_active", 64'(frame_active), 1);
    #5;
    rst = 1'b1;
    #1;
    check("mr_wr_valid", 64'(wr_valid), 0);
    check("mr_wr_data", 64'(wr_data), 0);
    check("mr_active", 64'(frame_active), 0);
    cyc();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) pix(16'h0070 + 16'(p), 1'b0, 1'b0, 1'b0);
    cyc();
    check("mr_drop_count", 64'(drop_count), 0);
    check("mr_frame_count", 64'(frame_count), 0);
    drain("mr_drained");

    // Clear colliding with an overflow
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vsync = 1'b1;
      pix(16'h0080 + 16'(i), 1'b1, 1'b1, 1'b0);
      vsync = 1'b0;
      cyc();
    end
    check("cc_drop5", 64'(drop_count), 5);
    pix(16'h0090, 1'b1, 1'b0, 1'b0);
    sready = 1'b0;
    clr    = 1'b1;
    cyc();
    sready = 1'b1;
    clr    = 1'b0;
    check("cc_drop_count", 64'(drop_count), 1);
    check("cc_ovf", 64'(ovf), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("cc_clr_drop", 64'(drop_count), 0);
    check("cc_clr_ovf", 64'(ovf), 0);
    drain("cc_drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
